// File: rtl/mmm_radix2_core_if.sv
// Operand/strobe/result bundle between the exponentiation control unit and the
// radix-2 Montgomery multiplier core.
interface mmm_radix2_core_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             rst_mmm;
  logic             ld_a;
  logic [WIDTH:0]   a_in;
  logic [WIDTH:0]   b_in;
  logic [WIDTH-1:0] m_in;
  logic [WIDTH:0]   result;
  logic             busy;
  logic             done;

  modport master (
    output en, rst_mmm, ld_a, a_in, b_in, m_in,
    input  result, busy, done
  );

  modport slave (
    input  en, rst_mmm, ld_a, a_in, b_in, m_in,
    output result, busy, done
  );
endinterface

// File: rtl/mmm_radix2_core.sv
// Radix-2 bit-serial Montgomery multiplier: result = A*B*2^-(WIDTH+2) mod M,
// left unreduced (< 2M), over WIDTH+2 clock-enabled iterations.
module mmm_radix2_core #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rstb,
  mmm_radix2_core_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 2);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH + 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH+1:0] r_q, r_d;
  logic [WIDTH:0]   result_q, result_d;
  logic [CntW-1:0]  i_q, i_d;

  logic [WIDTH+1:0] a_ext;
  logic             a_bit;
  logic [WIDTH+3:0] sum_s;
  logic [WIDTH+3:0] sum_t;
  logic [WIDTH+1:0] r_iter;
  logic             unused_sum;

  // Extra zero on top so the final iteration (i = WIDTH+1) reads A as 0.
  assign a_ext  = {1'b0, a_q};
  assign a_bit  = a_ext[i_q];
  assign sum_s  = {2'b00, r_q} + (a_bit ? {3'b000, b_q} : '0);
  assign sum_t  = sum_s + (sum_s[0] ? {4'b0000, m_q} : '0);
  assign r_iter = sum_t[WIDTH+2:1];

  // Bit 0 is zero by construction; the top bit cannot set for in-contract operands.
  assign unused_sum = ^{sum_t[WIDTH+3], sum_t[0]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    r_d      = r_q;
    result_d = result_q;
    i_d      = i_q;

    case (state_q)
      StRun: begin
        r_d = r_iter;
        i_d = i_q + 1'b1;
        if (i_q == LastIter) begin
          result_d = r_iter[WIDTH:0];
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      StIdle:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A load from any state restarts; an in-flight run is simply discarded.
    if (bus.ld_a) begin
      a_d     = bus.a_in;
      b_d     = bus.b_in;
      m_d     = bus.m_in;
      r_d     = '0;
      i_d     = '0;
      state_d = StRun;
    end

    if (!bus.rst_mmm) begin
      state_d  = StIdle;
      a_d      = '0;
      b_d      = '0;
      m_d      = '0;
      r_d      = '0;
      result_d = '0;
      i_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      result_q <= '0;
      i_q      <= '0;
    end else if (bus.en) begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      r_q      <= r_d;
      result_q <= result_d;
      i_q      <= i_d;
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = (state_q == StRun);
  assign bus.done   = (state_q == StDone);

endmodule

// File: tb/tb_mmm_radix2_core.sv
// Scoreboard bench for mmm_radix2_core (WIDTH=8): directed Montgomery vectors,
// stall/abort/clear/reset scenarios and a congruence sweep.
module tb_mmm_radix2_core;

  localparam int unsigned W = 8;

  // Check modes for a scoreboard entry.
  localparam int ModeNone  = 0;
  localparam int ModeExact = 1;
  localparam int ModeProp  = 2;
  localparam int ModeLat   = 3;

  typedef struct {
    int a;
    int b;
    int m;
    int mode;
    int expv;
    int lat;
    int start;
  } exp_t;

  logic clk;
  logic rstb;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  mmm_radix2_core_if #(.WIDTH(W)) bus ();

  mmm_radix2_core #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: on each rising done, pop the oldest expectation and compare.
  initial begin : monitor
    logic done_prev;
    exp_t e;
    int   r;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rstb && bus.done && !done_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          r = int'(bus.result);
          chk("latency", cyc - e.start, e.lat);
          if (e.mode == ModeExact) begin
            chk("result", r, e.expv);
          end else if (e.mode == ModeProp) begin
            chk("result_lt_2m", (r < 2 * e.m) ? 1 : 0, 1);
            chk("congruence", (r * 1024) % e.m, (e.a * e.b) % e.m);
          end
        end
      end
      done_prev = bus.done;
    end
  end

  // Call just after a negedge; returns at the negedge following the ld_a edge.
  task automatic issue(input int a, input int b, input int m, input int mode, input int expv,
                       input int lat);
    exp_t e;
    bus.ld_a = 1'b1;
    bus.a_in = a[W:0];
    bus.b_in = b[W:0];
    bus.m_in = m[W-1:0];
    if (mode != ModeNone) begin
      e.a = a; e.b = b; e.m = m; e.mode = mode; e.expv = expv; e.lat = lat;
      e.start = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.ld_a = 1'b0;
    // Scramble operand inputs to show they were latched.
    bus.a_in = (W + 1)'($urandom);
    bus.b_in = (W + 1)'($urandom);
    bus.m_in = W'($urandom);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin : stimulus
    int m, a, b;
    checks       = 0;
    errors       = 0;
    rstb         = 1'b0;
    bus.en       = 1'b1;
    bus.rst_mmm  = 1'b1;
    bus.ld_a     = 1'b0;
    bus.a_in     = '0;
    bus.b_in     = '0;
    bus.m_in     = '0;
    repeat (2) @(negedge clk);
    chk("reset_result", int'(bus.result), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    rstb = 1'b1;
    @(negedge clk);
    #1;

    // Basic run with busy window: 5*7*2^-10 mod 13 = 10.
    issue(5, 7, 13, ModeExact, 10, 10);
    for (int k = 0; k < 10; k++) begin
      chk("busy_run", int'(bus.busy), 1);
      @(negedge clk);
    end
    chk("busy_after", int'(bus.busy), 0);
    chk("done_high", int'(bus.done), 1);
    #1;
    wait_idle(30);
    @(negedge clk);
    chk("done_one_cycle", int'(bus.done), 0);
    #1;

    // 25*25 -> 4, then back-to-back 25*1 -> 9 loaded during the done cycle.
    issue(25, 25, 13, ModeExact, 4, 10);
    wait_idle(30);
    issue(25, 1, 13, ModeExact, 9, 10);
    wait_idle(30);

    // Abort a 25*25 run mid-flight with 5*7; only one done, prior result held.
    issue(25, 25, 13, ModeNone, 0, 0);
    repeat (5) @(negedge clk);
    chk("abort_prior_a", int'(bus.result), 9);
    #1;
    issue(5, 7, 13, ModeExact, 10, 10);
    repeat (5) @(negedge clk);
    chk("abort_prior_b", int'(bus.result), 9);
    chk("abort_no_done", int'(bus.done), 0);
    #1;
    wait_idle(30);

    // Stall with en low for five edges: done after 15 cycles.
    issue(5, 7, 13, ModeExact, 10, 15);
    repeat (3) @(negedge clk);
    bus.en = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_busy", int'(bus.busy), 1);
    bus.en = 1'b1;
    #1;
    wait_idle(30);

    // Synchronous clear mid-run, then a normal run.
    issue(25, 25, 13, ModeNone, 0, 0);
    repeat (3) @(negedge clk);
    bus.rst_mmm = 1'b0;
    @(negedge clk);
    bus.rst_mmm = 1'b1;
    chk("clr_result", int'(bus.result), 0);
    chk("clr_busy", int'(bus.busy), 0);
    chk("clr_done", int'(bus.done), 0);
    #1;
    issue(5, 7, 13, ModeExact, 10, 10);
    wait_idle(30);

    // Asynchronous reset mid-run takes effect without a clock edge.
    issue(25, 1, 13, ModeNone, 0, 0);
    repeat (4) @(negedge clk);
    #2;
    rstb = 1'b0;
    #1;
    chk("arst_result", int'(bus.result), 0);
    chk("arst_busy", int'(bus.busy), 0);
    @(negedge clk);
    rstb = 1'b1;
    #1;
    issue(25, 1, 13, ModeExact, 9, 10);
    wait_idle(30);

    // Out-of-contract even modulus: value undefined, timing still fixed.
    issue(300, 400, 12, ModeLat, 0, 10);
    wait_idle(30);

    // Congruence sweep, including the largest modulus with maximal operands.
    issue(509, 509, 255, ModeProp, 0, 10);
    wait_idle(30);
    issue(5, 5, 3, ModeProp, 0, 10);
    wait_idle(30);
    for (int v = 0; v < 20; v++) begin
      m = 2 * $urandom_range(1, 127) + 1;
      a = $urandom_range(0, 2 * m - 1);
      b = $urandom_range(0, 2 * m - 1);
      issue(a, b, m, ModeProp, 0, 10);
      wait_idle(30);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
